adc_scan_packetizer: RTL



---
 rtl/adc_scan_packetizer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_packetizer.sv
// Scans ADC channels each sample period, packs results into byte frames and
// buffers them in a show-ahead FIFO. Define ADC_PKT_CHTAG_EN to prepend a channel tag byte.
module adc_scan_packetizer #(
  parameter int NUM_CH     = 8,
  parameter int SAMPLE_DIV = 40000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic        adc_start,
  output logic [2:0]  adc_channel,
  input  logic        adc_ready,
  input  logic [11:0] adc_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow,
  output logic [15:0] drop_count,
  output logic        busy
);

  localparam int CW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
`ifdef ADC_PKT_CHTAG_EN
  localparam int FRAME_LEN = 3;
`else
  localparam int FRAME_LEN = 2;
`endif
  localparam logic [CW-1:0]   LAST_CNT    = CW'(SAMPLE_DIV - 1);
  localparam logic [2:0]      LAST_CH     = 3'(NUM_CH - 1);
  localparam logic [1:0]      LAST_IDX    = 2'(FRAME_LEN - 1);
  localparam logic [CNTW-1:0] SPACE_LIMIT = CNTW'(FIFO_DEPTH - FRAME_LEN);
  localparam logic [CNTW-1:0] FILL_ZERO   = CNTW'(0);
  localparam logic [CNTW-1:0] FILL_ONE    = CNTW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    PUSH  = 3'd3,
    NEXT  = 3'd4
  } state_t;

`ifdef ADC_PKT_CHTAG_EN
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [11:0] d,
                                            input logic [2:0] ch);
    case (idx)
      2'd0:    frame_byte = {2'b11, 3'b000, ch};
      2'd1:    frame_byte = {2'b10, d[11:6]};
      2'd2:    frame_byte = {2'b00, d[5:0]};
      default: frame_byte = 8'h00;
    endcase
  endfunction
`else
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [11:0] d);
    case (idx)
      2'd0:    frame_byte = {2'b10, d[11:6]};
      2'd1:    frame_byte = {2'b00, d[5:0]};
      default: frame_byte = 8'h00;
    endcase
  endfunction
`endif

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic [2:0]      chan_r;
  logic            start_r;
  logic            busy_r;
  logic [11:0]     data_r;
  logic [1:0]      idx_r;
  logic            overflow_r;
  logic [15:0]     drop_r;

  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] fill_r;
  logic [7:0]      head_r;
  logic            valid_r;

  logic            tick_s;
  logic            space_ok_s;
  logic            wr_en_s;
  logic [7:0]      wr_byte_s;
  logic            pop_s;
  logic [AW-1:0]   rd_nxt_s;
  logic [CNTW-1:0] fill_nxt_s;
  logic [7:0]      head_nxt_s;

  assign tick_s     = enable && (count_r == {CW{1'b0}});
  assign space_ok_s = (fill_r <= SPACE_LIMIT);
  assign pop_s      = valid_r && tx_ready;

  // Frame byte writer: the space check only gates the first byte of a frame.
  always_comb begin
    wr_en_s = 1'b0;
`ifdef ADC_PKT_CHTAG_EN
    wr_byte_s = frame_byte(idx_r, data_r, chan_r);
`else
    wr_byte_s = frame_byte(idx_r, data_r);
`endif
    if ((state_r == PUSH) && ((idx_r != 2'd0) || space_ok_s)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Next FIFO occupancy and next head byte, so tx_data/tx_valid can be registered.
  always_comb begin
    rd_nxt_s   = rd_ptr_r;
    fill_nxt_s = fill_r;
    head_nxt_s = 8'h00;
    if (pop_s) begin
      rd_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_nxt_s = rd_ptr_r;
    end
    case ({wr_en_s, pop_s})
      2'b10:   fill_nxt_s = fill_r + FILL_ONE;
      2'b01:   fill_nxt_s = fill_r - FILL_ONE;
      default: fill_nxt_s = fill_r;
    endcase
    if (fill_nxt_s == FILL_ZERO) begin
      head_nxt_s = 8'h00;
    end else if (wr_en_s && (fill_r == (pop_s ? FILL_ONE : FILL_ZERO))) begin
      head_nxt_s = wr_byte_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Period counter and scan sequencer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      count_r    <= {CW{1'b0}};
      chan_r     <= 3'd0;
      start_r    <= 1'b0;
      busy_r     <= 1'b0;
      data_r     <= 12'h000;
      idx_r      <= 2'd0;
      overflow_r <= 1'b0;
      drop_r     <= 16'h0000;
    end else begin
      if (!enable || (count_r == LAST_CNT)) begin
        count_r <= {CW{1'b0}};
      end else begin
        count_r <= count_r + CW'(1);
      end
      start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            chan_r  <= 3'd0;
            start_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= START;
          end
        end
        START: state_r <= WAIT;
        WAIT: begin
          if (adc_ready) begin
            data_r  <= adc_data;
            idx_r   <= 2'd0;
            state_r <= PUSH;
          end
        end
        PUSH: begin
          if ((idx_r == 2'd0) && !space_ok_s) begin
            overflow_r <= 1'b1;
            if (drop_r != 16'hFFFF) begin
              drop_r <= drop_r + 16'd1;
            end
            state_r <= NEXT;
          end else if (idx_r == LAST_IDX) begin
            idx_r   <= 2'd0;
            state_r <= NEXT;
          end else begin
            idx_r <= idx_r + 2'd1;
          end
        end
        NEXT: begin
          if ((chan_r == LAST_CH) || !enable) begin
            chan_r  <= 3'd0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            chan_r  <= chan_r + 3'd1;
            start_r <= 1'b1;
            state_r <= START;
          end
        end
        default: begin
          chan_r  <= 3'd0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_byte_s;
    end
  end

  // FIFO pointers, occupancy and registered head.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      fill_r   <= FILL_ZERO;
      head_r   <= 8'h00;
      valid_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_nxt_s;
      fill_r   <= fill_nxt_s;
      head_r   <= head_nxt_s;
      valid_r  <= (fill_nxt_s != FILL_ZERO);
    end
  end

  assign adc_start   = start_r;
  assign adc_channel = chan_r;
  assign busy        = busy_r;
  assign tx_data     = head_r;
  assign tx_valid    = valid_r;
  assign overflow    = overflow_r;
  assign drop_count  = drop_r;

endmodule
